// File: rtl/alu_seq_pkg.sv
// Shared constants for the ALU share sequencer: opcodes, ALU selects, FSM states.
// The MUL opcode only has meaning when the top is built with ALU_SEQ_MUL_EN.
package alu_seq_pkg;

  localparam int DATA_W = 8;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SHL  = 4'd5;
  localparam logic [3:0] OP_SHR  = 4'd6;
  localparam logic [3:0] OP_PASS = 4'd7;
  localparam logic [3:0] OP_MUL  = 4'd8;

  localparam logic [2:0] SEL_ADD = 3'd0;
  localparam logic [2:0] SEL_SUB = 3'd1;
  localparam logic [2:0] SEL_SHL = 3'd5;
  localparam logic [2:0] SEL_SHR = 3'd6;

  localparam logic [3:0] MUL_ITERS = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2,
    ST_RESP = 2'd3
  } seq_state_t;

endpackage

// File: rtl/alu_rr_arb2.sv
// Two-way arbiter: round-robin tie-break (or fixed priority to requester 0);
// the last-grant pointer only moves when a grant is actually accepted.
module alu_rr_arb2 #(
  parameter bit RR_FAIR = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);

  logic last_r;

  // Grant selection; a tie goes to the requester not granted last.
  always_comb begin
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (RR_FAIR && !last_r) ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

  // Last-grant pointer; starts at r1 so r0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_r <= 1'b1;
    end else if (accept) begin
      last_r <= gnt[1];
    end
  end

endmodule

// File: rtl/alu_share_sequencer.sv
// Shares one combinational ALU between two requesters, one command in flight.
// Define ALU_SEQ_MUL_EN to build the 8-pass shift-add multiply for opcode 8.
module alu_share_sequencer
  import alu_seq_pkg::*;
#(
  parameter int W       = DATA_W,
  parameter bit RR_FAIR = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           r0_valid,
  output logic           r0_ready,
  input  logic [3:0]     r0_op,
  input  logic [W-1:0]   r0_a,
  input  logic [W-1:0]   r0_b,
  input  logic           r1_valid,
  output logic           r1_ready,
  input  logic [3:0]     r1_op,
  input  logic [W-1:0]   r1_a,
  input  logic [W-1:0]   r1_b,
  output logic [W-1:0]   alu_a,
  output logic [W-1:0]   alu_b,
  output logic [2:0]     alu_sel,
  input  logic [W-1:0]   alu_result,
  input  logic           alu_carry,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic           rsp_id,
  output logic [2*W-1:0] rsp_result,
  output logic           rsp_carry,
  output logic           rsp_err,
  output logic           busy
);

  seq_state_t     state_r;
  logic [1:0]     gnt_s;
  logic           idle_s;
  logic           accept_s;
  logic           win_id_s;
  logic [3:0]     win_op_s;
  logic [W-1:0]   win_a_s;
  logic [W-1:0]   win_b_s;
  logic [W-1:0]   alu_a_r;
  logic [W-1:0]   alu_b_r;
  logic [2:0]     alu_sel_r;
  logic           cmd_id_r;
  logic           rsp_valid_r;
  logic           rsp_id_r;
  logic [2*W-1:0] rsp_result_r;
  logic           rsp_carry_r;
  logic           rsp_err_r;
  logic           busy_r;
`ifdef ALU_SEQ_MUL_EN
  logic [W-1:0]   cmd_a_r;
  logic [W-1:0]   mul_hi_r;
  logic [W-1:0]   mul_lo_r;
  logic [3:0]     mul_cnt_r;
`endif

  assign idle_s   = (state_r == ST_IDLE);
  assign accept_s = idle_s && (gnt_s != 2'b00);
  assign r0_ready = idle_s && gnt_s[0];
  assign r1_ready = idle_s && gnt_s[1];

  alu_rr_arb2 #(.RR_FAIR(RR_FAIR)) u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    ({r1_valid, r0_valid}),
    .accept (accept_s),
    .gnt    (gnt_s)
  );

  // Mux the granted requester's command toward the command register.
  always_comb begin
    win_id_s = gnt_s[1];
    if (gnt_s[1]) begin
      win_op_s = r1_op;
      win_a_s  = r1_a;
      win_b_s  = r1_b;
    end else begin
      win_op_s = r0_op;
      win_a_s  = r0_a;
      win_b_s  = r0_b;
    end
  end

  // Sequencer FSM: ALU operands for the next cycle are registered here, so the
  // ALU pins stay at zero outside EXEC/MUL and drop at once on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      alu_a_r      <= {W{1'b0}};
      alu_b_r      <= {W{1'b0}};
      alu_sel_r    <= 3'd0;
      cmd_id_r     <= 1'b0;
      rsp_valid_r  <= 1'b0;
      rsp_id_r     <= 1'b0;
      rsp_result_r <= {2*W{1'b0}};
      rsp_carry_r  <= 1'b0;
      rsp_err_r    <= 1'b0;
      busy_r       <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      cmd_a_r      <= {W{1'b0}};
      mul_hi_r     <= {W{1'b0}};
      mul_lo_r     <= {W{1'b0}};
      mul_cnt_r    <= 4'd0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            cmd_id_r <= win_id_s;
            busy_r   <= 1'b1;
            if (!win_op_s[3]) begin
              state_r   <= ST_EXEC;
              alu_a_r   <= win_a_s;
              alu_b_r   <= win_b_s;
              alu_sel_r <= win_op_s[2:0];
`ifdef ALU_SEQ_MUL_EN
            end else if (win_op_s == OP_MUL) begin
              state_r   <= ST_MUL;
              cmd_a_r   <= win_a_s;
              mul_hi_r  <= {W{1'b0}};
              mul_lo_r  <= win_b_s;
              mul_cnt_r <= 4'd0;
              alu_a_r   <= {W{1'b0}};
              alu_b_r   <= win_b_s[0] ? win_a_s : {W{1'b0}};
              alu_sel_r <= SEL_ADD;
`endif
            end else begin
              state_r      <= ST_RESP;
              rsp_valid_r  <= 1'b1;
              rsp_id_r     <= win_id_s;
              rsp_result_r <= {2*W{1'b0}};
              rsp_carry_r  <= 1'b0;
              rsp_err_r    <= 1'b1;
            end
          end
        end
        ST_EXEC: begin
          state_r      <= ST_RESP;
          rsp_valid_r  <= 1'b1;
          rsp_id_r     <= cmd_id_r;
          rsp_result_r <= {{W{1'b0}}, alu_result};
          rsp_carry_r  <= alu_carry;
          rsp_err_r    <= 1'b0;
          alu_a_r      <= {W{1'b0}};
          alu_b_r      <= {W{1'b0}};
          alu_sel_r    <= 3'd0;
        end
`ifdef ALU_SEQ_MUL_EN
        ST_MUL: begin
          if (mul_cnt_r != MUL_ITERS) begin
            {mul_hi_r, mul_lo_r} <= {alu_carry, alu_result, mul_lo_r[W-1:1]};
            mul_cnt_r            <= mul_cnt_r + 4'd1;
            if (mul_cnt_r == (MUL_ITERS - 4'd1)) begin
              alu_a_r   <= {W{1'b0}};
              alu_b_r   <= {W{1'b0}};
              alu_sel_r <= 3'd0;
            end else begin
              // Next pass adds a when the bit about to reach lo[0] is set.
              alu_a_r   <= {alu_carry, alu_result[W-1:1]};
              alu_b_r   <= mul_lo_r[1] ? cmd_a_r : {W{1'b0}};
              alu_sel_r <= SEL_ADD;
            end
          end else begin
            state_r      <= ST_RESP;
            rsp_valid_r  <= 1'b1;
            rsp_id_r     <= cmd_id_r;
            rsp_result_r <= {mul_hi_r, mul_lo_r};
            rsp_carry_r  <= 1'b0;
            rsp_err_r    <= 1'b0;
          end
        end
`endif
        ST_RESP: begin
          if (rsp_ready) begin
            state_r      <= ST_IDLE;
            busy_r       <= 1'b0;
            rsp_valid_r  <= 1'b0;
            rsp_id_r     <= 1'b0;
            rsp_result_r <= {2*W{1'b0}};
            rsp_carry_r  <= 1'b0;
            rsp_err_r    <= 1'b0;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          busy_r      <= 1'b0;
          rsp_valid_r <= 1'b0;
          alu_a_r     <= {W{1'b0}};
          alu_b_r     <= {W{1'b0}};
          alu_sel_r   <= 3'd0;
        end
      endcase
    end
  end

  assign alu_a      = alu_a_r;
  assign alu_b      = alu_b_r;
  assign alu_sel    = alu_sel_r;
  assign rsp_valid  = rsp_valid_r;
  assign rsp_id     = rsp_id_r;
  assign rsp_result = rsp_result_r;
  assign rsp_carry  = rsp_carry_r;
  assign rsp_err    = rsp_err_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_alu_share_sequencer.sv
// Scoreboard bench for alu_share_sequencer with a behavioural ALU attached.
// MUL expectations follow ALU_SEQ_MUL_EN, matching the build of the design.
module tb_alu_share_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        r0_valid, r0_ready, r1_valid, r1_ready;
  logic [3:0]  r0_op, r1_op;
  logic [7:0]  r0_a, r0_b, r1_a, r1_b;
  logic [7:0]  alu_a, alu_b, alu_result;
  logic [2:0]  alu_sel;
  logic        alu_carry;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_carry, rsp_err, busy;
  logic [15:0] rsp_result;

  typedef struct packed {
    logic        id;
    logic [15:0] res;
    logic        carry;
    logic        err;
    logic [3:0]  lat;
    logic [31:0] t_acc;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] cyc = 32'd0;
  logic [31:0] last_acc = 32'd0;
  logic [31:0] prev_acc;
  logic        last_gnt;
  logic        rsp_seen;
  logic [7:0]  ra, rb;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 32'd1;

  alu_share_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .r0_valid   (r0_valid),
    .r0_ready   (r0_ready),
    .r0_op      (r0_op),
    .r0_a       (r0_a),
    .r0_b       (r0_b),
    .r1_valid   (r1_valid),
    .r1_ready   (r1_ready),
    .r1_op      (r1_op),
    .r1_a       (r1_a),
    .r1_b       (r1_b),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sel    (alu_sel),
    .alu_result (alu_result),
    .alu_carry  (alu_carry),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_carry  (rsp_carry),
    .rsp_err    (rsp_err),
    .busy       (busy)
  );

  function automatic logic [8:0] alu_model(input logic [2:0] sel, input logic [7:0] a, input logic [7:0] b);
    case (sel)
      3'd0:    return {1'b0, a} + {1'b0, b};
      3'd1:    return {1'b0, a} - {1'b0, b};
      3'd2:    return {1'b0, a & b};
      3'd3:    return {1'b0, a | b};
      3'd4:    return {1'b0, a ^ b};
      3'd5:    return {1'b0, a[6:0], 1'b0};
      3'd6:    return {2'b00, a[7:1]};
      default: return {1'b0, a};
    endcase
  endfunction

  assign {alu_carry, alu_result} = alu_model(alu_sel, alu_a, alu_b);

  function automatic exp_t make_exp(input logic id, input logic [3:0] op, input logic [7:0] a,
                                    input logic [7:0] b, input logic [31:0] t);
    exp_t       e;
    logic [8:0] r;
    e.id = id; e.t_acc = t; e.res = 16'h0000; e.carry = 1'b0; e.err = 1'b0;
    if (!op[3]) begin
      r = alu_model(op[2:0], a, b);
      e.res = {8'h00, r[7:0]}; e.carry = r[8]; e.lat = 4'd2;
`ifdef ALU_SEQ_MUL_EN
    end else if (op == 4'd8) begin
      e.res = {8'h00, a} * {8'h00, b}; e.lat = 4'd10;
`endif
    end else begin
      e.err = 1'b1; e.lat = 4'd1;
    end
    return e;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Response monitor: latency on first sight, content on handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      rsp_seen <= 1'b0;
    end else begin
      if (rsp_valid || !busy)
        check_eq("alu_quiet", {13'd0, alu_sel, alu_a, alu_b}, 32'd0);
      if (rsp_valid && !rsp_seen) begin
        if (sb_q.size() == 0) check_eq("rsp_unexpected", 32'd1, 32'd0);
        else check_eq("rsp_latency", cyc - sb_q[0].t_acc, {28'd0, sb_q[0].lat});
        rsp_seen <= 1'b1;
      end
      if (rsp_valid && rsp_ready) begin
        if (sb_q.size() != 0) begin
          mon_e = sb_q.pop_front();
          check_eq("rsp_id", {31'd0, rsp_id}, {31'd0, mon_e.id});
          check_eq("rsp_result", {16'd0, rsp_result}, {16'd0, mon_e.res});
          check_eq("rsp_flags", {30'd0, rsp_carry, rsp_err}, {30'd0, mon_e.carry, mon_e.err});
        end
        rsp_seen <= 1'b0;
      end
    end
  end

  task automatic send(input logic id, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    int   n = 0;
    bit   done = 1'b0;
    if (id) begin r1_valid = 1'b1; r1_op = op; r1_a = a; r1_b = b; end
    else    begin r0_valid = 1'b1; r0_op = op; r0_a = a; r0_b = b; end
    #1;
    while (!done && n < 40) begin
      if (id ? r1_ready : r0_ready) begin
        e = make_exp(id, op, a, b, cyc);
        done = 1'b1;
      end else begin
        @(negedge clk);
        n++;
      end
    end
    if (!done) begin
      check_eq("ready_timeout", 32'd0, 32'd1);
      r0_valid = 1'b0; r1_valid = 1'b0;
      return;
    end
    @(posedge clk);
    sb_q.push_back(e);
    last_gnt = id;
    last_acc = e.t_acc;
    #1 r0_valid = 1'b0; r1_valid = 1'b0;
    @(negedge clk);
    if (!op[3])
      check_eq("alu_drive", {13'd0, alu_sel, alu_a, alu_b}, {13'd0, op[2:0], a, b});
`ifdef ALU_SEQ_MUL_EN
    else if (op == 4'd8)
      check_eq("mul_drive", {13'd0, alu_sel, alu_a, alu_b}, {13'd0, 3'd0, 8'h00, (b[0] ? a : 8'h00)});
`endif
  endtask

  task automatic tie_round(input logic [7:0] a0, input logic [7:0] a1);
    exp_t e;
    int   n = 0;
    logic exp_w;
    r0_valid = 1'b1; r0_op = 4'd0; r0_a = a0; r0_b = 8'h01;
    r1_valid = 1'b1; r1_op = 4'd4; r1_a = a1; r1_b = 8'hFF;
    #1;
    while (!(r0_ready || r1_ready) && n < 40) begin @(negedge clk); n++; end
    exp_w = !last_gnt;
    check_eq("tie_grant", {30'd0, r1_ready, r0_ready}, exp_w ? 32'd2 : 32'd1);
    if (r1_ready) e = make_exp(1'b1, 4'd4, a1, 8'hFF, cyc);
    else          e = make_exp(1'b0, 4'd0, a0, 8'h01, cyc);
    if (r0_ready || r1_ready) begin
      @(posedge clk);
      sb_q.push_back(e);
      last_gnt = e.id;
    end
    #1 r0_valid = 1'b0; r1_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb_q.size() != 0 || rsp_valid) && n < 60) begin @(negedge clk); n++; end
    check_eq("drain", sb_q.size(), 32'd0);
  endtask

  task automatic reset_mid(input logic [3:0] op, input int waitn);
    send(1'b0, op, 8'h0D, 8'h0B);
    repeat (waitn) @(negedge clk);
    check_eq("pre_reset_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("reset_mid_rsp", {11'd0, rsp_valid, busy, rsp_id, rsp_result, rsp_carry, rsp_err}, 32'd0);
    check_eq("reset_mid_alu", {13'd0, alu_sel, alu_a, alu_b}, 32'd0);
    sb_q.delete();
    last_gnt = 1'b1;
    @(posedge clk); @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; rsp_ready = 1'b1; last_gnt = 1'b1;
    r0_valid = 1'b0; r0_op = 4'd0; r0_a = 8'h00; r0_b = 8'h00;
    r1_valid = 1'b0; r1_op = 4'd0; r1_a = 8'h00; r1_b = 8'h00;
    repeat (3) @(negedge clk);
    check_eq("reset_rsp", {11'd0, rsp_valid, busy, rsp_id, rsp_result, rsp_carry, rsp_err}, 32'd0);
    check_eq("reset_alu", {13'd0, alu_sel, alu_a, alu_b}, 32'd0);
    check_eq("reset_ready", {30'd0, r1_ready, r0_ready}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Simultaneous requests alternate r0, r1, r0, r1 from reset.
    for (int i = 0; i < 4; i++) begin
      tie_round(8'h10 + 8'(i), 8'h30 + 8'(i));
      drain();
    end

    send(1'b0, 4'd0, 8'hF0, 8'h20);
    drain();

    // Response held while the consumer stalls; no command accepted meanwhile.
    rsp_ready = 1'b0;
    send(1'b0, 4'd1, 8'h05, 8'h07);
    @(negedge clk);
    r0_valid = 1'b1; r0_op = 4'd0; r1_valid = 1'b1; r1_op = 4'd2;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("hold_rsp", {10'd0, rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_err, 2'b00},
               {10'd0, 1'b1, 1'b0, 16'h00FE, 1'b1, 1'b0, 2'b00});
      check_eq("hold_ready", {30'd0, r1_ready, r0_ready}, 32'd0);
    end
    @(posedge clk);
    #1 r0_valid = 1'b0; r1_valid = 1'b0; rsp_ready = 1'b1;
    drain();

    send(1'b1, 4'd12, 8'hAA, 8'h55);
    drain();
    send(1'b0, 4'd8, 8'hFF, 8'hFF);
    drain();
    send(1'b1, 4'd8, 8'h0D, 8'h0B);
    drain();

    // Back-to-back commands: one accept every three cycles.
    for (int i = 0; i < 6; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      if (i == 3) ra = 8'h80;
      prev_acc = last_acc;
      send(i[0], 4'(i + 2), ra, rb);
      if (i > 0) check_eq("b2b_gap", last_acc - prev_acc, 32'd3);
    end
    drain();

    reset_mid(4'd2, 0);
    send(1'b1, 4'd0, 8'h7F, 8'h01);
    drain();
`ifdef ALU_SEQ_MUL_EN
    reset_mid(4'd8, 3);
    send(1'b1, 4'd8, 8'h0D, 8'h0B);
    drain();
`endif

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
